// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared constants and helpers for the divided-clock generator
package clk_gen_pkg;

    localparam int MIN_DIV = 2;

    // Reset ratio of channel idx: 2, 4, 8, ...
    function automatic int default_div(input int idx);
        return 1 << (idx + 1);
    endfunction

    function automatic bit params_legal(input int num_clks, input int div_w, input int sel_w);
        return (num_clks >= 1) && (div_w > num_clks) && (div_w <= 31) &&
               (sel_w >= $clog2(num_clks));
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divided-clock channel with pending-ratio update on wrap
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] rst_div,
    output logic             div_clk,
    output logic             stb
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pend;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] half;
    logic             pend_v;
    logic             armed;

    always_comb begin
        cnt_nxt = (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        half    = div >> 1;
    end

    // armed keeps the output low until the first full period after reset,
    // so the first high phase is never truncated.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div     <= rst_div;
            pend    <= '0;
            pend_v  <= 1'b0;
            armed   <= 1'b0;
            div_clk <= 1'b0;
            stb     <= 1'b0;
        end else begin
            if (sync) begin
                cnt     <= '0;
                div_clk <= 1'b1;
                stb     <= 1'b1;
                armed   <= 1'b1;
                if (pend_v) begin
                    div    <= pend;
                    pend_v <= 1'b0;
                end
            end else if (enable) begin
                cnt     <= cnt_nxt;
                stb     <= (cnt_nxt == '0);
                div_clk <= (armed || cnt_nxt == '0) && (cnt_nxt < half);
                if (cnt_nxt == '0) begin
                    armed <= 1'b1;
                    if (pend_v) begin
                        div    <= pend;
                        pend_v <= 1'b0;
                    end
                end
            end else begin
                stb <= 1'b0;
            end
            // A write in the same cycle as an apply becomes the next pending value.
            if (wr) begin
                pend   <= wr_div;
                pend_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_gen_param.sv
// rtl/clk_gen_param.sv - multi-channel divided-clock generator with config port
module clk_gen_param
    import clk_gen_pkg::*;
#(
    parameter int NUM_CLKS = 3,
    parameter int DIV_W    = 8,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [NUM_CLKS-1:0] clks,
    output logic [NUM_CLKS-1:0] div_stb,
    output logic                cfg_ack,
    output logic                cfg_err
);

    if (!params_legal(NUM_CLKS, DIV_W, SEL_W)) begin : g_param_check
        $error("clk_gen_param: illegal NUM_CLKS/DIV_W/SEL_W combination");
    end

    logic                cfg_ok;
    logic [NUM_CLKS-1:0] wr;

    assign cfg_ok = cfg_we && (32'(cfg_sel) < NUM_CLKS) && (cfg_div >= DIV_W'(MIN_DIV));

    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
        assign wr[i] = cfg_ok && (32'(cfg_sel) == i);

        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .rst_div (DIV_W'(default_div(i))),
            .div_clk (clks[i]),
            .stb     (div_stb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_ok;
            cfg_err <= cfg_we && !cfg_ok;
        end
    end

endmodule
